// File: rtl/rst_interrupt_controller.sv
// RST-vector interrupt controller: two vga_clk-domain level requests, pending latches,
// INTA acknowledge FSM that places an RST opcode on the CPU data bus, and an overrun counter.
module rst_interrupt_controller #(
  parameter int XLEN        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            irq_mid,
  input  logic            irq_vblank,
  input  logic            inta,
  input  logic            dbin,
  output logic            iint,
  inout  tri   [XLEN-1:0] data,
  output logic [7:0]      overrun_count
);

  localparam logic [XLEN-1:0] VEC_MID   = XLEN'(8'hCF);
  localparam logic [XLEN-1:0] VEC_VBL   = XLEN'(8'hD7);
  localparam logic [XLEN-1:0] VEC_SPUR  = XLEN'(8'hFF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_mid_r;
  logic [SYNC_STAGES-1:0] sync_vbl_r;
  logic [SYNC_STAGES:0]   fill_r;
  logic                   prev_mid_r;
  logic                   prev_vbl_r;
  logic                   edge_mid_s;
  logic                   edge_vbl_s;
  logic                   pending_mid_r;
  logic                   pending_vbl_r;
  logic                   pending_mid_s;
  logic                   pending_vbl_s;
  logic                   clr_mid_s;
  logic                   clr_vbl_s;
  logic                   iint_r;
  state_t                 state_r;
  state_t                 state_s;
  logic                   latch_s;
  logic [XLEN-1:0]        vector_r;
  logic [XLEN-1:0]        vec_out_s;
  logic                   drive_s;
  logic [1:0]             ov_inc_s;
  logic [8:0]             ov_sum_s;
  logic [7:0]             overrun_s;
  logic [7:0]             overrun_r;

  function automatic logic [XLEN-1:0] sel_vector(input logic pm, input logic pv);
    logic [XLEN-1:0] v;
    if (pm) begin
      v = VEC_MID;
    end else if (pv) begin
      v = VEC_VBL;
    end else begin
      v = VEC_SPUR;
    end
    return v;
  endfunction

  // Synchronizers, edge history and a fill marker. Edges are ignored until the
  // history flop holds a genuine sample, so a level already high at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_mid_r <= '0;
      sync_vbl_r <= '0;
      fill_r     <= '0;
      prev_mid_r <= 1'b0;
      prev_vbl_r <= 1'b0;
    end else begin
      sync_mid_r <= {sync_mid_r[SYNC_STAGES-2:0], irq_mid};
      sync_vbl_r <= {sync_vbl_r[SYNC_STAGES-2:0], irq_vblank};
      fill_r     <= {fill_r[SYNC_STAGES-1:0], 1'b1};
      prev_mid_r <= sync_mid_r[SYNC_STAGES-1];
      prev_vbl_r <= sync_vbl_r[SYNC_STAGES-1];
    end
  end

  assign edge_mid_s = sync_mid_r[SYNC_STAGES-1] & ~prev_mid_r & fill_r[SYNC_STAGES];
  assign edge_vbl_s = sync_vbl_r[SYNC_STAGES-1] & ~prev_vbl_r & fill_r[SYNC_STAGES];

  assign clr_mid_s = (state_r == ACK) & ~dbin & (vector_r == VEC_MID);
  assign clr_vbl_s = (state_r == ACK) & ~dbin & (vector_r == VEC_VBL);

  // Pending next state: a new edge beats a simultaneous clear.
  always_comb begin
    pending_mid_s = pending_mid_r;
    pending_vbl_s = pending_vbl_r;
    if (edge_mid_s) begin
      pending_mid_s = 1'b1;
    end else if (clr_mid_s) begin
      pending_mid_s = 1'b0;
    end else begin
      pending_mid_s = pending_mid_r;
    end
    if (edge_vbl_s) begin
      pending_vbl_s = 1'b1;
    end else if (clr_vbl_s) begin
      pending_vbl_s = 1'b0;
    end else begin
      pending_vbl_s = pending_vbl_r;
    end
  end

  // Overrun: each edge that lands on an already-pending source costs one count.
  always_comb begin
    ov_inc_s  = {1'b0, edge_mid_s & pending_mid_r} + {1'b0, edge_vbl_s & pending_vbl_r};
    ov_sum_s  = {1'b0, overrun_r} + {7'd0, ov_inc_s};
    overrun_s = ov_sum_s[8] ? 8'hFF : ov_sum_s[7:0];
  end

  // Pending bits, registered iint and the saturating overrun counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mid_r <= 1'b0;
      pending_vbl_r <= 1'b0;
      iint_r        <= 1'b0;
      overrun_r     <= 8'h00;
    end else begin
      pending_mid_r <= pending_mid_s;
      pending_vbl_r <= pending_vbl_s;
      iint_r        <= pending_mid_r | pending_vbl_r;
      overrun_r     <= overrun_s;
    end
  end

  // Acknowledge FSM next state.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (dbin && inta) begin
          state_s = ACK;
          latch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACK: begin
        if (!dbin) begin
          state_s = DONE;
        end else begin
          state_s = ACK;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and vector latched on entry to ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      vector_r <= VEC_SPUR;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        vector_r <= sel_vector(pending_mid_r, pending_vbl_r);
      end
    end
  end

  // First dbin cycle uses the live mux so data is valid in the cycle dbin rises.
  assign drive_s   = rst_n & dbin & inta & ((state_r == IDLE) | (state_r == ACK));
  assign vec_out_s = (state_r == ACK) ? vector_r : sel_vector(pending_mid_r, pending_vbl_r);
  assign data      = drive_s ? vec_out_s : {XLEN{1'bz}};

  assign iint          = iint_r;
  assign overrun_count = overrun_r;

endmodule

// File: tb/tb_rst_interrupt_controller.sv
// Scoreboard bench for rst_interrupt_controller: directed scenarios plus random
// pulse/read traffic checked against an event-level model of pending requests.
module tb_rst_interrupt_controller;
  localparam int XLEN = 8;
  localparam int S    = 2;

  logic clk = 1'b0;
  logic rst_n, irq_mid, irq_vblank, inta, dbin, iint;
  logic [7:0] overrun_count;
  tri   [XLEN-1:0] data;

  for (genvar g = 0; g < XLEN; g++) begin : g_pd
    pulldown pd (data[g]);
  end

  rst_interrupt_controller #(.XLEN(XLEN), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .irq_mid(irq_mid), .irq_vblank(irq_vblank),
    .inta(inta), .dbin(dbin), .iint(iint), .data(data), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Model state: which sources have an unacknowledged request, and lost-request count.
  bit m_mid, m_vbl;
  int m_ov;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_vec();
    if (m_mid) return 8'hCF;
    if (m_vbl) return 8'hD7;
    return 8'hFF;
  endfunction

  function automatic void model_req(input bit mid);
    if (mid) begin
      if (m_mid) m_ov = (m_ov < 255) ? m_ov + 1 : 255;
      m_mid = 1'b1;
    end else begin
      if (m_vbl) m_ov = (m_ov < 255) ? m_ov + 1 : 255;
      m_vbl = 1'b1;
    end
  endfunction

  function automatic void model_ack();
    if (m_mid) m_mid = 1'b0;
    else if (m_vbl) m_vbl = 1'b0;
  endfunction

  // Monitor: pops an expected vector for every driven read cycle, else expects the bus released.
  always @(negedge clk) begin
    if (dbin && inta && rst_n) begin
      if (exp_q.size() == 0) begin
        chk("data_unexpected", data, 8'h00);
      end else begin
        chk("data_vec", data, exp_q.pop_front());
      end
    end else if (dbin) begin
      chk("data_released", data, 8'h00);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic d, input logic a, input logic [7:0] e);
    dbin = d;
    inta = a;
    if (d && a) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit pm, input bit pv);
    if (pm) model_req(1'b1);
    if (pv) model_req(1'b0);
    irq_mid = pm;
    irq_vblank = pv;
    idle(2);
    irq_mid = 1'b0;
    irq_vblank = 1'b0;
    idle(S + 4);
  endtask

  // INTA read of n dbin cycles; inta is withdrawn from cycle index drop onward.
  task automatic do_read(input int n, input int drop);
    logic [7:0] v;
    v = model_vec();
    for (int i = 0; i < n; i++) cyc(1'b1, (i < drop), v);
    model_ack();
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_mid = 1'b0;
    m_vbl = 1'b0;
    m_ov = 0;
    idle(S + 3);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_iint"}, {7'd0, iint}, {7'd0, (m_mid | m_vbl)});
    chk({tag, "_ovr"}, overrun_count, m_ov[7:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; irq_mid = 1'b1; irq_vblank = 1'b0; inta = 1'b0; dbin = 1'b0;
    m_mid = 1'b0; m_vbl = 1'b0; m_ov = 0;
    idle(3);
    chk("rst_iint", {7'd0, iint}, 8'h00);
    chk("rst_ovr", overrun_count, 8'h00);
    rst_n = 1'b1;
    idle(10);
    chk_model("high_at_release");
    irq_mid = 1'b0;
    idle(S + 3);

    // Single mid request: latency then a 3-cycle read.
    irq_mid = 1'b1;
    idle(S + 1);
    chk("lat_early", {7'd0, iint}, 8'h00);
    idle(1);
    chk("lat_iint", {7'd0, iint}, 8'h01);
    irq_mid = 1'b0;
    model_req(1'b1);
    idle(S + 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'hCF);
    model_ack();
    cyc(1'b0, 1'b0, 8'h00);
    chk("iint_hold", {7'd0, iint}, 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    chk("iint_clear", {7'd0, iint}, 8'h00);
    idle(2);

    // Both at once, then two reads in priority order.
    pulse(1'b1, 1'b1);
    chk_model("both");
    do_read(2, 2);
    chk_model("between");
    do_read(2, 2);
    chk_model("after_two");

    // Spurious acknowledge.
    do_read(2, 2);
    chk_model("spurious");

    // New vblank edge lands exactly on the clear cycle.
    pulse(1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'hD7);
    irq_vblank = 1'b1;
    model_req(1'b0);
    repeat (S) cyc(1'b1, 1'b1, 8'hD7);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    irq_vblank = 1'b0;
    idle(S + 3);
    chk_model("coincide");
    do_read(1, 1);
    chk_model("coincide_read");

    // Overrun counting and saturation from a fresh reset.
    do_reset();
    chk_model("post_reset");
    repeat (3) pulse(1'b0, 1'b1);
    chk_model("ovr_three");
    chk("ovr_two", overrun_count, 8'h02);
    repeat (300) pulse(1'b0, 1'b1);
    chk_model("ovr_sat");
    chk("ovr_ff", overrun_count, 8'hFF);
    do_read(2, 2);

    // Reset in the middle of ACK.
    pulse(1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'hCF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_iint", {7'd0, iint}, 8'h00);
    chk("async_data", data, 8'h00);
    @(posedge clk);
    #1;
    dbin = 1'b0; inta = 1'b0;
    idle(1);
    rst_n = 1'b1;
    m_mid = 1'b0; m_vbl = 1'b0; m_ov = 0;
    idle(S + 3);
    chk_model("after_abort");
    do_read(2, 2);
    chk_model("after_abort_read");

    // Random traffic.
    for (int k = 0; k < 80; k++) begin
      int op, n, drop;
      op = $urandom_range(0, 4);
      case (op)
        0: pulse(1'b1, 1'b0);
        1: pulse(1'b0, 1'b1);
        2: pulse(1'b1, 1'b1);
        3: begin
          n = $urandom_range(1, 4);
          drop = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : n;
          do_read(n, drop);
        end
        default: begin
          n = $urandom_range(1, 3);
          repeat (n) cyc(1'b1, 1'b0, 8'h00);
          cyc(1'b0, 1'b0, 8'h00);
        end
      endcase
      chk_model("rand");
    end

    idle(2);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_interrupt_controller.md
RST_INTERRUPT_CONTROLLER -- requirements
Module: rst_interrupt_controller

Interface
REQ-001 SHALL have parameter XLEN, default 8, data bus width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for the interrupt request inputs (minimum 2).
REQ-003 SHALL have port clk  input  1  CPU clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_mid  input  1  mid-screen request, level, from the vga_clk domain.
REQ-006 SHALL have port irq_vblank  input  1  vblank request, level, from the vga_clk domain.
REQ-007 SHALL have port inta  input  1  latched status INTA bit of the current machine cycle.
REQ-008 SHALL have port dbin  input  1  CPU data-bus-in strobe.
REQ-009 SHALL have port iint  output  1  interrupt request to the CPU.
REQ-010 SHALL have port data  tri  XLEN  CPU data bus; the block drives it only during an acknowledge read and otherwise leaves it high-Z.
REQ-011 SHALL have port overrun_count  output  8  count of lost requests, saturating.

Function
REQ-012 SHALL pass each irq input through a SYNC_STAGES flop chain on clk before any other use.
REQ-013 SHALL detect a rising edge on each synchronized irq and set that source's pending bit on the following clk edge.
REQ-014 SHALL drive iint = pending_mid | pending_vblank, registered, and SHALL hold it until the source is acknowledged.
REQ-015 SHALL use states IDLE, ACK and DONE. IDLE->ACK on the first cycle with dbin & inta. ACK->DONE on the first cycle with dbin deasserted. DONE->IDLE unconditionally after one cycle.
REQ-016 On IDLE->ACK, SHALL latch the selected vector, with priority mid over vblank: mid gives 0xCF (RST 1), vblank-only gives 0xD7 (RST 2), neither pending gives 0xFF (RST 7, spurious).
REQ-017 SHALL drive the latched vector on data in every cycle where state is ACK and dbin & inta; the data value SHALL NOT change during ACK even if the pending bits change.
REQ-018 Combinational output is permitted for the first dbin cycle of a read (the vector mux from the current pending bits), so that data is valid within the same cycle dbin rises.
REQ-019 On ACK->DONE, SHALL clear the pending bit of the acknowledged source only; a spurious acknowledge clears nothing.
REQ-020 If a new rising edge of a source coincides with the clear of that same source, set SHALL win and the bit SHALL remain pending.
REQ-021 A rising edge on a source whose pending bit is already set SHALL increment overrun_count by 1, saturating at 0xFF with no wrap.
REQ-022 Simultaneous rising edges on both sources SHALL set both pending bits in the same cycle.
REQ-023 dbin without inta SHALL NOT change state and SHALL NOT drive data.
REQ-024 If inta drops while in ACK, SHALL stop driving data immediately and still take the ACK->DONE clear when dbin falls.

Reset
REQ-025 On rst_n low, SHALL asynchronously clear the synchronizers, edge-detect history, both pending bits, the state (to IDLE), the latched vector (to 0xFF) and overrun_count (to 0x00).
REQ-026 During reset, iint SHALL be 0 and data SHALL be high-Z.
REQ-027 A level that is already high on an irq at reset release SHALL NOT be treated as an edge; it requires a low-then-high transition.
REQ-028 Reset asserted in the middle of ACK SHALL abort the acknowledge; no pending bit survives.

Verification
REQ-029 Pulse irq_mid, then run one INTA read of 3 dbin cycles -> iint=1 within SYNC_STAGES+2 clk; data=0xCF during dbin; iint=0 two cycles after dbin falls.
REQ-030 Raise irq_mid and irq_vblank in the same cycle, then run two INTA reads -> first read returns 0xCF, second returns 0xD7; iint stays 1 between the reads and is 0 after the second.
REQ-031 Run an INTA read with nothing pending -> data=0xFF; iint stays 0; pending stays 00.
REQ-032 Pulse irq_vblank 3 times with no acknowledge -> overrun_count=2, iint=1; after 300 further pulses -> overrun_count=0xFF.
REQ-033 Start an acknowledge of vblank and produce a new vblank edge in the clear cycle -> data=0xD7, and pending_vblank remains 1 afterwards.
REQ-034 Assert rst_n=0 in ACK with both bits pending -> data goes high-Z, iint=0, and state=IDLE immediately, without waiting for a clk edge.
